// File: rtl/neck_pkg.sv
// Shared widths, saturation limits and the 14-to-13-bit saturation helper
// for the neck-detection difference generator.
package neck_pkg;

  localparam int DATA_W  = 13;
  localparam int ADC_W   = 12;
  localparam int SAT_MAX = 4095;
  localparam int SAT_MIN = -4096;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Clamp a 14-bit signed difference into the 13-bit judge range.
  function automatic sample_t sat13(input logic signed [DATA_W:0] v);
    if (v > 14'sd4095) begin
      return 13'sd4095;
    end else if (v < -14'sd4096) begin
      return 13'sh1000;
    end else begin
      return sample_t'(v[DATA_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/lag_diff.sv
// LAG-deep history ring for one derivative order: diff_o = x_i - x[n-LAG],
// saturated. Combinational through, history written on valid_i.
module lag_diff
  import neck_pkg::*;
#(
  parameter int LAG = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    valid_i,
  input  sample_t x_i,
  output sample_t diff_o,
  output logic    valid_o
);

  localparam int PTR_W = (LAG > 1) ? $clog2(LAG) : 1;

  sample_t                ring_q [LAG];
  logic    [PTR_W-1:0]    ptr_q;
  logic    [PTR_W-1:0]    ptr_d;
  logic signed [DATA_W:0] wide_s;

  always_comb begin
    wide_s  = {x_i[DATA_W-1], x_i} - {ring_q[ptr_q][DATA_W-1], ring_q[ptr_q]};
    diff_o  = sat13(wide_s);
    valid_o = valid_i;
    if (ptr_q == PTR_W'(LAG - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < LAG; i++) ring_q[i] <= '0;
    end else if (valid_i) begin
      ring_q[ptr_q] <= x_i;
      ptr_q         <= ptr_d;
    end
  end

endmodule

// File: rtl/neck_diff_gen.sv
// Decimate, smooth and difference ADC samples for the neck judge (3-cycle latency).
// Build option NECK_DIFF_AVG_EN enables the 2^AVG_LOG2 moving average.
module neck_diff_gen
  import neck_pkg::*;
#(
  parameter int DECIM    = 10,
  parameter int AVG_LOG2 = 2,
  parameter int LAG      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_raw,
  output sample_t          adc_data,
  output sample_t          first_order_data,
  output sample_t          second_order_data,
  output sample_t          third_order_data,
  output logic             en_judge,
  output logic             primed
);

  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef NECK_DIFF_AVG_EN
  localparam int WARM = (1 << AVG_LOG2) + 3 * LAG;
`else
  localparam int WARM = 3 * LAG;
`endif
  localparam int WCNT_W = $clog2(WARM + 1);

  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              taken_s;
  logic              elig_s;
  logic [ADC_W-1:0]  avg_s;

  logic    s1_valid_q, s1_elig_q, s2_valid_q, s2_elig_q;
  sample_t s1_avg_q, s2_avg_q, s2_d1_q;
  sample_t d1_s, d2_s, d3_s;
  logic    d1_valid_s, d2_valid_s, d3_valid_s;
  logic    primed_q, en_q;
  sample_t adc_q, d1_q, d2_q, d3_q;

  // A sample is eligible to strobe once it, counted itself, completes warm-up.
  always_comb begin
    dcnt_d  = dcnt_q;
    taken_s = 1'b0;
    if (adc_valid) begin
      if (dcnt_q == DCNT_W'(DECIM - 1)) begin
        dcnt_d  = '0;
        taken_s = 1'b1;
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end else begin
      dcnt_d = dcnt_q;
    end
    if (taken_s && (wcnt_q != WCNT_W'(WARM))) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end else begin
      wcnt_d = wcnt_q;
    end
    elig_s = (wcnt_d == WCNT_W'(WARM));
  end

`ifdef NECK_DIFF_AVG_EN
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int SUM_W = ADC_W + AVG_LOG2;

  logic [ADC_W-1:0] shreg_q [AVG_N];
  logic [SUM_W-1:0] sum_q, sum_d;

  // Running sum stays exact: it always equals the sum of the shift register.
  always_comb begin
    sum_d = sum_q + SUM_W'(adc_raw) - SUM_W'(shreg_q[AVG_N-1]);
    avg_s = ADC_W'(sum_d >> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      for (int i = 0; i < AVG_N; i++) shreg_q[i] <= '0;
    end else if (taken_s) begin
      sum_q      <= sum_d;
      shreg_q[0] <= adc_raw;
      for (int i = 1; i < AVG_N; i++) shreg_q[i] <= shreg_q[i-1];
    end
  end
`else
  always_comb avg_s = adc_raw;
`endif

  lag_diff #(.LAG(LAG)) u_d1 (
    .clk(clk), .rst(rst), .valid_i(s1_valid_q), .x_i(s1_avg_q),
    .diff_o(d1_s), .valid_o(d1_valid_s)
  );

  lag_diff #(.LAG(LAG)) u_d2 (
    .clk(clk), .rst(rst), .valid_i(s2_valid_q), .x_i(s2_d1_q),
    .diff_o(d2_s), .valid_o(d2_valid_s)
  );

  lag_diff #(.LAG(LAG)) u_d3 (
    .clk(clk), .rst(rst), .valid_i(d2_valid_s), .x_i(d2_s),
    .diff_o(d3_s), .valid_o(d3_valid_s)
  );

  // Three-stage pipeline: avg, d1, then d2/d3 into the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q     <= '0;
      wcnt_q     <= '0;
      primed_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_elig_q  <= 1'b0;
      s1_avg_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_elig_q  <= 1'b0;
      s2_avg_q   <= '0;
      s2_d1_q    <= '0;
      en_q       <= 1'b0;
      adc_q      <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      d3_q       <= '0;
    end else begin
      dcnt_q     <= dcnt_d;
      wcnt_q     <= wcnt_d;
      primed_q   <= (wcnt_d == WCNT_W'(WARM));
      s1_valid_q <= taken_s;
      if (taken_s) begin
        s1_avg_q  <= sample_t'({1'b0, avg_s});
        s1_elig_q <= elig_s;
      end
      s2_valid_q <= d1_valid_s;
      if (d1_valid_s) begin
        s2_avg_q  <= s1_avg_q;
        s2_d1_q   <= d1_s;
        s2_elig_q <= s1_elig_q;
      end
      en_q <= d3_valid_s & s2_elig_q;
      if (d3_valid_s) begin
        adc_q <= s2_avg_q;
        d1_q  <= s2_d1_q;
        d2_q  <= d2_s;
        d3_q  <= d3_s;
      end
    end
  end

  assign adc_data          = adc_q;
  assign first_order_data  = d1_q;
  assign second_order_data = d2_q;
  assign third_order_data  = d3_q;
  assign en_judge          = en_q;
  assign primed            = primed_q;

endmodule

// File: tb/tb_neck_diff_gen.sv
// Randomized bench for neck_diff_gen against a sample-indexed reference model.
// Follows NECK_DIFF_AVG_EN the same way as the design build.
module tb_neck_diff_gen;

  localparam int DECIM    = 3;
  localparam int AVG_LOG2 = 2;
  localparam int LAG      = 8;
`ifdef NECK_DIFF_AVG_EN
  localparam int WARM = (1 << AVG_LOG2) + 3 * LAG;
`else
  localparam int WARM = 3 * LAG;
`endif
  localparam int HMAX = 4096;

  logic               clk;
  logic               rst;
  logic               adc_valid;
  logic [11:0]        adc_raw;
  logic signed [12:0] adc_data, first_order_data, second_order_data, third_order_data;
  logic               en_judge, primed;

  neck_diff_gen #(.DECIM(DECIM), .AVG_LOG2(AVG_LOG2), .LAG(LAG)) dut (
    .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_raw(adc_raw),
    .adc_data(adc_data), .first_order_data(first_order_data),
    .second_order_data(second_order_data), .third_order_data(third_order_data),
    .en_judge(en_judge), .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference history, indexed by taken-sample number (1-based, 0 before start)
  int xs [HMAX];
  int av [HMAX];
  int h1 [HMAX];
  int h2 [HMAX];
  int h3 [HMAX];
  int dcnt_m = 0;
  int n_m    = 0;

  // In-flight results: slot 0 just taken, slot 1 one edge older
  bit p_v [2];
  bit p_e [2];
  int p_a [2];
  int p_1 [2];
  int p_2 [2];
  int p_3 [2];
  int e_a = 0, e_1 = 0, e_2 = 0, e_3 = 0, e_en = 0, e_pr = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 4095) return 4095;
    if (v < -4096) return -4096;
    return v;
  endfunction

  function automatic int past(input int k);
    return (k >= 1) ? k : 0;
  endfunction

  task automatic model_take(input int raw);
    int s;
    n_m++;
    xs[n_m] = raw;
`ifdef NECK_DIFF_AVG_EN
    s = 0;
    for (int i = 0; i < (1 << AVG_LOG2); i++)
      if (n_m - i >= 1) s += xs[n_m - i];
    av[n_m] = s / (1 << AVG_LOG2);
`else
    av[n_m] = raw;
`endif
    h1[n_m] = sat(av[n_m] - ((n_m > LAG) ? av[n_m - LAG] : 0));
    h2[n_m] = sat(h1[n_m] - ((n_m > LAG) ? h1[n_m - LAG] : 0));
    h3[n_m] = sat(h2[n_m] - ((n_m > LAG) ? h3[past(0)] * 0 + h2[n_m - LAG] : 0));
    p_v[0] = 1'b1;
    p_e[0] = (n_m >= WARM);
    p_a[0] = av[n_m];
    p_1[0] = h1[n_m];
    p_2[0] = h2[n_m];
    p_3[0] = h3[n_m];
  endtask

  task automatic step(input bit v, input int raw, input bit r, output bit tk);
    rst       = r;
    adc_valid = v;
    adc_raw   = 12'(raw);
    tk        = 1'b0;
    @(posedge clk);
    #1;
    if (r) begin
      dcnt_m = 0;
      n_m    = 0;
      p_v[0] = 1'b0;
      p_v[1] = 1'b0;
      e_a = 0; e_1 = 0; e_2 = 0; e_3 = 0; e_en = 0; e_pr = 0;
    end else begin
      tk = v && (dcnt_m == DECIM - 1);
      if (v) dcnt_m = tk ? 0 : dcnt_m + 1;
      e_en = 0;
      if (p_v[1]) begin
        e_a = p_a[1]; e_1 = p_1[1]; e_2 = p_2[1]; e_3 = p_3[1];
        e_en = p_e[1] ? 1 : 0;
      end
      p_v[1] = p_v[0]; p_e[1] = p_e[0]; p_a[1] = p_a[0];
      p_1[1] = p_1[0]; p_2[1] = p_2[0]; p_3[1] = p_3[0];
      p_v[0] = 1'b0;
      if (tk) model_take(raw);
      e_pr = (n_m >= WARM) ? 1 : 0;
    end
    chk("en_judge", int'(en_judge), e_en);
    chk("primed", int'(primed), e_pr);
    chk("adc_data", int'(adc_data), e_a);
    chk("d1", int'(first_order_data), e_1);
    chk("d2", int'(second_order_data), e_2);
    chk("d3", int'(third_order_data), e_3);
  endtask

  initial begin
    bit tk;
    int k;
    int first_n;
    int cnt;
    int run;
    int max_run;
    for (int i = 0; i < HMAX; i++) begin
      xs[i] = 0; av[i] = 0; h1[i] = 0; h2[i] = 0; h3[i] = 0;
    end
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    rst = 1'b1; adc_valid = 1'b0; adc_raw = 12'd0;

    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, tk);

    // Constant 2000: first strobe belongs to the WARM-th taken sample
    first_n = -1;
    for (int i = 0; i < 40 * DECIM; i++) begin
      step(1'b1, 2000, 1'b0, tk);
      if (en_judge && first_n < 0) first_n = n_m;
    end
    chk("first_en_n", first_n, WARM);
    chk("const_adc", int'(adc_data), 2000);
    chk("const_d1", int'(first_order_data), 0);
    chk("const_d2", int'(second_order_data), 0);
    chk("const_d3", int'(third_order_data), 0);
    chk("const_primed", int'(primed), 1);

    // Reset at steady state with a valid sample in the same cycle
    step(1'b1, 2000, 1'b1, tk);
    chk("rst_adc", int'(adc_data), 0);
    chk("rst_primed", int'(primed), 0);

    // Ramp +4 per taken sample from 0
    k = 0;
    for (int i = 0; i < 60 * DECIM; i++) begin
      step(1'b1, 4 * k, 1'b0, tk);
      if (tk) k++;
    end
    chk("ramp_d1", int'(first_order_data), 32);
    chk("ramp_d2", int'(second_order_data), 0);
    chk("ramp_d3", int'(third_order_data), 0);

    // Square wave, 8 taken samples low then 8 high
    step(1'b0, 0, 1'b1, tk);
    k = 0;
    for (int i = 0; i < 80 * DECIM; i++) begin
      step(1'b1, ((k / 8) % 2 == 1) ? 4095 : 0, 1'b0, tk);
      if (tk) k++;
    end

    // Random data, random valid, rare resets
    for (int i = 0; i < 900; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
           ($urandom_range(0, 299) == 0), tk);
    end

    // Full scale held, then strobe spacing with valid held high
    step(1'b0, 0, 1'b1, tk);
    for (int i = 0; i < 40 * DECIM; i++) step(1'b1, 4095, 1'b0, tk);
    chk("fs_adc", int'(adc_data), 4095);
    chk("fs_d1", int'(first_order_data), 0);
    cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 10 * DECIM; i++) begin
      step(1'b1, 4095, 1'b0, tk);
      if (en_judge) begin
        cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    chk("en_count", cnt, 10);
    chk("en_width", max_run, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
